// File: rtl/instr_mem_prog_if.sv
// instr_mem_prog_if: fetch and program-load signals of the writable instruction memory
interface instr_mem_prog_if #(
  parameter int AW = 8
);
  logic          fetch_req;
  logic [31:0]   pc;
  logic [31:0]   id;
  logic          id_valid;
  logic          id_fault;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_count;
  logic [31:0]   ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_done;
  logic          busy;
  modport master (
    output fetch_req, pc, ld_start, ld_base, ld_count, ld_data, ld_valid,
    input  id, id_valid, id_fault, ld_ready, ld_done, busy
  );
  modport slave (
    input  fetch_req, pc, ld_start, ld_base, ld_count, ld_data, ld_valid,
    output id, id_valid, id_fault, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/instr_mem_prog.sv
// instr_mem_prog: writable instruction memory with 1-cycle fetch and streaming load; IMEM_PARITY_EN adds per-word parity
module instr_mem_prog #(
  parameter int          DEPTH      = 256,
  parameter int          AW         = $clog2(DEPTH),
  parameter logic [31:0] ILLOP_WORD = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  instr_mem_prog_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [31:0]   id_q, id_d;
  logic          id_valid_q, id_valid_d;
  logic          id_fault_q, id_fault_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_done_q, ld_done_d;
  logic          busy_q, busy_d;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] ridx;
  logic          start, acc, fetch_ok, addr_bad, par_bad;
`ifdef IMEM_PARITY_EN
  logic          par [DEPTH];
  assign par_bad = par[ridx] != ^mem[ridx];
`else
  assign par_bad = 1'b0;
`endif
  assign cnt      = bus.ld_count > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.ld_count;
  assign ridx     = bus.pc[AW+1:2];
  assign start    = state_q == S_IDLE && bus.ld_start;
  assign acc      = state_q == S_LOAD && bus.ld_valid;
  assign fetch_ok = bus.fetch_req && state_q != S_LOAD;
  assign addr_bad = bus.pc[1:0] != 2'b00 || bus.pc[31:2] >= 30'(DEPTH);
  // Next-state: load sequencing and fetch result; fetches stall while loading
  always_comb begin
    state_d    = state_q == S_IDLE ? (start ? (cnt == '0 ? S_DONE : S_LOAD) : S_IDLE) :
                 state_q == S_LOAD ? (acc && rem_q == (AW+1)'(1) ? S_DONE : S_LOAD) : S_IDLE;
    ptr_d      = start ? bus.ld_base : acc ? ptr_q + 1'b1 : ptr_q;
    rem_d      = start ? cnt : acc ? rem_q - 1'b1 : rem_q;
    id_fault_d = fetch_ok && (addr_bad || par_bad);
    id_d       = !fetch_ok ? id_q : id_fault_d ? ILLOP_WORD : mem[ridx];
    id_valid_d = fetch_ok;
    ld_ready_d = state_d == S_LOAD;
    busy_d     = state_d == S_LOAD;
    ld_done_d  = state_d == S_DONE;
  end
  // State and registered outputs; reset aborts any burst without ld_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      id_fault_q <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
      id_fault_q <= id_fault_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      busy_q     <= busy_d;
    end
  end
  // Storage is never cleared; one write per accepted load word
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[ptr_q] <= bus.ld_data;
`ifdef IMEM_PARITY_EN
      par[ptr_q] <= ^bus.ld_data;
`endif
    end
  end
  assign bus.id       = id_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_fault = id_fault_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.busy     = busy_q;
endmodule
